mem_arbiter: RTL and testbench

- Two-requester arbiter that shares the single Avalon-style memory port (32-bit word RAM, byteenable, waitrequest) between the CPU instruction-fetch port and the data load/store port.
- Sits between the MIPS core and the memory.
- Serialises one transaction at a time and applies round-robin on contention.
- Adds a watchdog that force-completes a transaction if memory holds waitrequest too long.

---
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data load-store) arbiter onto one Avalon-style word memory port.
// Latency: one IDLE arbitration cycle, then completion in the first grant cycle with mem_waitrequest=0.
// Backpressure: the non-granted port sees waitrequest=1; a watchdog force-completes long memory stalls.
module mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        i_read,
    input  logic [31:0] i_address,
    output logic [31:0] i_readdata,
    output logic        i_waitrequest,

    input  logic        d_read,
    input  logic        d_write,
    input  logic [3:0]  d_byteenable,
    input  logic [31:0] d_address,
    input  logic [31:0] d_writedata,
    output logic [31:0] d_readdata,
    output logic        d_waitrequest,

    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_byteenable,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_waitrequest,

    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    // Counter value seen in the stalled cycle that becomes the forced completion.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic             last_grant_d;
    logic [CNT_W-1:0] cnt;

    logic i_req;
    logic d_req;
    logic gnt_req;
    logic stall_last;
    logic done;
    logic forced;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

    always_comb begin
        gnt_req = 1'b0;
        case (state)
            GRANT_I: gnt_req = i_req;
            GRANT_D: gnt_req = d_req;
            default: gnt_req = 1'b0;
        endcase
    end

    // A transaction whose requester has withdrawn never completes, even if memory is ready.
    assign stall_last = mem_waitrequest && (cnt == CNT_LAST);
    assign done       = gnt_req && (!mem_waitrequest || stall_last);
    assign forced     = gnt_req && stall_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            last_grant_d <= 1'b1;
            cnt          <= '0;
            timeout_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                if (state_nxt != IDLE) begin
                    last_grant_d <= (state_nxt == GRANT_D);
                    cnt          <= '0;
                end
            end else if (mem_waitrequest && (cnt != CNT_LAST)) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (forced) begin
                timeout_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_req && d_req) begin
                    state_nxt = last_grant_d ? GRANT_I : GRANT_D;
                end else if (i_req) begin
                    state_nxt = GRANT_I;
                end else if (d_req) begin
                    state_nxt = GRANT_D;
                end else begin
                    state_nxt = IDLE;
                end
            end
            GRANT_I, GRANT_D: begin
                if (!gnt_req || done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_byteenable = 4'b0000;
        mem_address    = 32'h0000_0000;
        mem_writedata  = 32'h0000_0000;
        i_waitrequest  = 1'b1;
        d_waitrequest  = 1'b1;
        i_readdata     = 32'h0000_0000;
        d_readdata     = 32'h0000_0000;
        case (state)
            GRANT_I: begin
                mem_read       = i_read;
                mem_address    = i_address;
                mem_byteenable = 4'b1111;
                i_waitrequest  = !done;
                if (done && !forced) begin
                    i_readdata = mem_readdata;
                end
            end
            GRANT_D: begin
                // Simultaneous read+write is treated as a write.
                mem_read       = d_read & ~d_write;
                mem_write      = d_write;
                mem_byteenable = d_byteenable;
                mem_address    = d_address;
                mem_writedata  = d_writedata;
                d_waitrequest  = !done;
                if (done && !forced && !d_write) begin
                    d_readdata = mem_readdata;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle-by-cycle vector table plus memory-model sequences.
module tb_mem_arbiter;

    localparam logic [31:0] IA = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_read;
    logic [31:0] i_address;
    logic [31:0] i_readdata;
    logic        i_waitrequest;
    logic        d_read;
    logic        d_write;
    logic [3:0]  d_byteenable;
    logic [31:0] d_address;
    logic [31:0] d_writedata;
    logic [31:0] d_readdata;
    logic        d_waitrequest;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_waitrequest;
    logic        timeout_err;

    logic        use_model;
    logic [31:0] tv_rdata;
    logic        tv_wait;
    logic [31:0] ram [0:15];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign mem_readdata    = use_model ? ram[mem_address[5:2]] : tv_rdata;
    assign mem_waitrequest = use_model ? 1'b0 : tv_wait;

    mem_arbiter #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut (
        .clk            (clk),
        .reset          (reset),
        .i_read         (i_read),
        .i_address      (i_address),
        .i_readdata     (i_readdata),
        .i_waitrequest  (i_waitrequest),
        .d_read         (d_read),
        .d_write        (d_write),
        .d_byteenable   (d_byteenable),
        .d_address      (d_address),
        .d_writedata    (d_writedata),
        .d_readdata     (d_readdata),
        .d_waitrequest  (d_waitrequest),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_address    (mem_address),
        .mem_writedata  (mem_writedata),
        .mem_readdata   (mem_readdata),
        .mem_waitrequest(mem_waitrequest),
        .timeout_err    (timeout_err)
    );

    typedef struct packed {
        logic        mr;
        logic        mw;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        iw;
        logic        dw;
        logic [31:0] ird;
        logic [31:0] drd;
        logic        te;
    } out_t;

    typedef struct {
        string       name;
        logic        rst;
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dwr;
        logic [3:0]  dbe;
        logic [31:0] da;
        logic [31:0] dwd;
        logic [31:0] mrd;
        logic        mwait;
        out_t        exp;
    } vec_t;

    vec_t tbl[$];

    function automatic out_t o_idle(logic te);
        return '{1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 32'h0, te};
    endfunction

    function automatic out_t o_gi(logic [31:0] a, logic dn, logic [31:0] rd, logic te);
        return '{1'b1, 1'b0, 4'hF, a, 32'h0, !dn, 1'b1, rd, 32'h0, te};
    endfunction

    function automatic out_t o_gd(logic mr, logic mw, logic [3:0] be, logic [31:0] a,
                                  logic [31:0] wd, logic dn, logic [31:0] rd, logic te);
        return '{mr, mw, be, a, wd, 1'b1, !dn, 32'h0, rd, te};
    endfunction

    function automatic vec_t mk(string nm, logic rst, logic ir, logic [31:0] ia,
                                logic dr, logic dwr, logic [3:0] dbe, logic [31:0] da,
                                logic [31:0] dwd, logic [31:0] mrd, logic mwait, out_t ex);
        vec_t v;
        v.name = nm; v.rst = rst; v.ir = ir; v.ia = ia; v.dr = dr; v.dwr = dwr;
        v.dbe = dbe; v.da = da; v.dwd = dwd; v.mrd = mrd; v.mwait = mwait; v.exp = ex;
        return v;
    endfunction

    function automatic out_t cur_out();
        return '{mem_read, mem_write, mem_byteenable, mem_address, mem_writedata,
                 i_waitrequest, d_waitrequest, i_readdata, d_readdata, timeout_err};
    endfunction

    task automatic check_out(string nm, out_t act, out_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_int(string nm, longint act, longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        i_read = 0; i_address = 0; d_read = 0; d_write = 0;
        d_byteenable = 0; d_address = 0; d_writedata = 0;
        tv_rdata = 0; tv_wait = 0;
    endtask

    task automatic ram_write_if_any();
        if (mem_write && !mem_waitrequest) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_byteenable[b]) ram[mem_address[5:2]][8*b +: 8] = mem_writedata[8*b +: 8];
            end
        end
    endtask

    initial begin
        int order[$];
        logic drop_i;
        logic drop_d;
        int nc;
        int ni;
        int nd;
        int port;

        use_model = 0;
        for (int k = 0; k < 16; k++) ram[k] = 32'h0;
        clear_inputs();
        reset = 1;

        // Each record is one clock: inputs held for the cycle, outputs checked before the edge.
        tbl.push_back(mk("idle_after_reset", 0, 0, 0,  0, 0, 4'h0, 0, 0, 32'h1234_5678, 0, o_idle(0)));
        tbl.push_back(mk("i_arb",            0, 1, IA, 0, 0, 4'h0, 0, 0, 32'h2402_0005, 0, o_idle(0)));
        tbl.push_back(mk("i_cpl",            0, 1, IA, 0, 0, 4'h0, 0, 0, 32'h2402_0005, 0, o_gi(IA, 1, 32'h2402_0005, 0)));
        tbl.push_back(mk("idle_1",           0, 0, 0,  0, 0, 4'h0, 0, 0, 32'h0, 0, o_idle(0)));
        tbl.push_back(mk("d_arb",            0, 0, 0,  1, 0, 4'hF, 32'h100, 0, 32'hCAFE_F00D, 1, o_idle(0)));
        for (int k = 1; k <= 3; k++)
            tbl.push_back(mk($sformatf("d_stall%0d", k), 0, 0, 0, 1, 0, 4'hF, 32'h100, 0, 32'hCAFE_F00D, 1,
                             o_gd(1, 0, 4'hF, 32'h100, 0, 0, 0, 0)));
        tbl.push_back(mk("d_cpl_4th",        0, 0, 0,  1, 0, 4'hF, 32'h100, 0, 32'hCAFE_F00D, 0,
                         o_gd(1, 0, 4'hF, 32'h100, 0, 1, 32'hCAFE_F00D, 0)));
        tbl.push_back(mk("idle_2",           0, 0, 0,  0, 0, 4'h0, 0, 0, 32'h0, 0, o_idle(0)));
        tbl.push_back(mk("tmo_arb",          0, 0, 0,  1, 0, 4'hF, 32'h200, 0, 32'h55AA_55AA, 1, o_idle(0)));
        for (int k = 1; k <= 3; k++)
            tbl.push_back(mk($sformatf("tmo_stall%0d", k), 0, 0, 0, 1, 0, 4'hF, 32'h200, 0, 32'h55AA_55AA, 1,
                             o_gd(1, 0, 4'hF, 32'h200, 0, 0, 0, 0)));
        tbl.push_back(mk("tmo_force",        0, 0, 0,  1, 0, 4'hF, 32'h200, 0, 32'h55AA_55AA, 1,
                         o_gd(1, 0, 4'hF, 32'h200, 0, 1, 32'h0, 0)));
        tbl.push_back(mk("tmo_sticky",       0, 0, 0,  0, 0, 4'h0, 0, 0, 32'h0, 1, o_idle(1)));
        tbl.push_back(mk("sticky_i_arb",     0, 1, IA, 0, 0, 4'h0, 0, 0, 32'h2402_0005, 0, o_idle(1)));
        tbl.push_back(mk("sticky_i_cpl",     0, 1, IA, 0, 0, 4'h0, 0, 0, 32'h2402_0005, 0, o_gi(IA, 1, 32'h2402_0005, 1)));
        tbl.push_back(mk("drop_arb",         0, 0, 0,  0, 1, 4'h1, 32'h300, 32'h11, 32'h0, 1, o_idle(1)));
        tbl.push_back(mk("drop_stall",       0, 0, 0,  0, 1, 4'h1, 32'h300, 32'h11, 32'h0, 1,
                         o_gd(0, 1, 4'h1, 32'h300, 32'h11, 0, 0, 1)));
        tbl.push_back(mk("drop_req",         0, 0, 0,  0, 0, 4'h1, 32'h300, 32'h11, 32'h99, 0,
                         o_gd(0, 0, 4'h1, 32'h300, 32'h11, 0, 0, 1)));
        tbl.push_back(mk("drop_idle",        0, 0, 0,  0, 0, 4'h0, 0, 0, 32'h99, 0, o_idle(1)));
        tbl.push_back(mk("rw_arb",           0, 0, 0,  1, 1, 4'hF, 32'h400, 32'hA5, 32'h77, 0, o_idle(1)));
        tbl.push_back(mk("rw_cpl",           0, 0, 0,  1, 1, 4'hF, 32'h400, 32'hA5, 32'h77, 0,
                         o_gd(0, 1, 4'hF, 32'h400, 32'hA5, 1, 0, 1)));
        tbl.push_back(mk("rw_idle",          0, 0, 0,  0, 0, 4'h0, 0, 0, 32'h77, 0, o_idle(1)));
        tbl.push_back(mk("rst_arb",          0, 0, 0,  1, 0, 4'hF, 32'h500, 0, 32'h66, 1, o_idle(1)));
        tbl.push_back(mk("rst_stall",        0, 0, 0,  1, 0, 4'hF, 32'h500, 0, 32'h66, 1,
                         o_gd(1, 0, 4'hF, 32'h500, 0, 0, 0, 1)));
        tbl.push_back(mk("rst_pulse",        1, 0, 0,  1, 0, 4'hF, 32'h500, 0, 32'h66, 1,
                         o_gd(1, 0, 4'hF, 32'h500, 0, 0, 0, 1)));
        tbl.push_back(mk("rst_after",        0, 0, 0,  1, 0, 4'hF, 32'h500, 0, 32'h66, 1, o_idle(0)));
        tbl.push_back(mk("reissue",          0, 0, 0,  1, 0, 4'hF, 32'h500, 0, 32'h66, 1,
                         o_gd(1, 0, 4'hF, 32'h500, 0, 0, 0, 0)));
        tbl.push_back(mk("reissue_drop",     0, 0, 0,  0, 0, 4'hF, 32'h500, 0, 32'h66, 1,
                         o_gd(0, 0, 4'hF, 32'h500, 0, 0, 0, 0)));
        tbl.push_back(mk("final_idle",       0, 0, 0,  0, 0, 4'h0, 0, 0, 32'h0, 0, o_idle(0)));

        repeat (2) @(posedge clk);

        foreach (tbl[k]) begin
            @(negedge clk);
            reset        = tbl[k].rst;
            i_read       = tbl[k].ir;
            i_address    = tbl[k].ia;
            d_read       = tbl[k].dr;
            d_write      = tbl[k].dwr;
            d_byteenable = tbl[k].dbe;
            d_address    = tbl[k].da;
            d_writedata  = tbl[k].dwd;
            tv_rdata     = tbl[k].mrd;
            tv_wait      = tbl[k].mwait;
            #1;
            check_out(tbl[k].name, cur_out(), tbl[k].exp);
        end

        // Simultaneous I read and D byte-lane write from reset: I wins, then D writes low half.
        @(negedge clk);
        clear_inputs();
        use_model = 1;
        ram[0] = 32'h2402_0005;
        ram[4] = 32'h1234_5678;
        reset = 1;
        @(negedge clk);
        reset = 0;
        i_read = 1; i_address = IA;
        d_write = 1; d_address = 32'hBFC0_0010; d_writedata = 32'hDEAD_BEEF; d_byteenable = 4'b0011;
        drop_i = 0;
        drop_d = 0;
        for (int c = 0; c < 20 && order.size() < 2; c++) begin
            if (c > 0) @(negedge clk);
            if (drop_i) i_read = 0;
            if (drop_d) d_write = 0;
            drop_i = 0;
            drop_d = 0;
            #1;
            ram_write_if_any();
            if (!i_waitrequest) begin
                order.push_back(0);
                check_int("prio_i_rdata", i_readdata, 32'h2402_0005);
                check_int("prio_i_be", mem_byteenable, 4'hF);
                drop_i = 1;
            end
            if (!d_waitrequest) begin
                order.push_back(1);
                check_int("prio_d_rdata_write", d_readdata, 0);
                drop_d = 1;
            end
        end
        check_int("prio_completions", order.size(), 2);
        if (order.size() >= 2) begin
            check_int("prio_first_is_i", order[0], 0);
            check_int("prio_second_is_d", order[1], 1);
        end
        check_int("prio_ram_bytelanes", ram[4], 32'h1234_BEEF);

        // Continuous contention: grants must alternate I,D,I,D... with 4 completions each.
        @(negedge clk);
        if (drop_i) i_read = 0;
        if (drop_d) d_write = 0;
        i_read = 1; i_address = IA;
        d_read = 1; d_write = 0; d_address = 32'hBFC0_0010; d_byteenable = 4'hF;
        nc = 0; ni = 0; nd = 0;
        for (int c = 0; c < 40 && nc < 8; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            check_int("rr_exclusive", int'(!i_waitrequest && !d_waitrequest), 0);
            if (!i_waitrequest || !d_waitrequest) begin
                port = !i_waitrequest ? 0 : 1;
                check_int($sformatf("rr_grant%0d", nc), port, nc % 2);
                if (port == 0) begin
                    ni++;
                    check_int("rr_i_rdata", i_readdata, 32'h2402_0005);
                end else begin
                    nd++;
                    check_int("rr_d_rdata", d_readdata, 32'h1234_BEEF);
                end
                nc++;
            end
        end
        check_int("rr_i_count", ni, 4);
        check_int("rr_d_count", nd, 4);
        check_int("rr_no_timeout", timeout_err, 0);

        @(negedge clk);
        clear_inputs();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
